// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch unit: FSM states, byte geometry,
// the default NOP and the big-endian byte-lane mapping.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        HALT  = 3'd4
    } fetch_state_e;

    localparam int          BYTE_W           = 8;
    localparam int          BYTES_PER_WORD   = 4;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    // MIPS big-endian: byte 0 of a word lands in bits 31:24, byte 3 in bits 7:0.
    function automatic logic [4:0] byte_lane_lsb(input logic [1:0] idx);
        return 5'd24 - {idx, 3'b000};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_byte_assembler.sv
// Four-lane capture register: loads one byte per strobe into the big-endian lane
// selected by idx; clear (or reset) returns the whole word to CLEAR_WORD.
module byte_assembler
    import fetch_pkg::*;
#(
    parameter logic [31:0] CLEAR_WORD = DEFAULT_NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [1:0]        idx,
    input  logic [BYTE_W-1:0] din,
    output logic [31:0]       word
);

    logic [31:0] word_q;
    logic [31:0] word_d;

    // Next word: clear wins over a lane load.
    always_comb begin
        word_d = word_q;
        if (clear) begin
            word_d = CLEAR_WORD;
        end else if (load) begin
            word_d[byte_lane_lsb(idx) +: BYTE_W] = din;
        end else begin
            word_d = word_q;
        end
    end

    // Word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= CLEAR_WORD;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads four bytes of the word at pc from a byte-wide synchronous
// ROM, assembles them big-endian and pulses clock_enable once per completed fetch.
// Define FETCH_CACHE_EN to add a one-entry {pc, word} cache that turns repeat fetches into 1-cycle hits.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] NOP_WORD    = DEFAULT_NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              clock_enable,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              align_fault,
    output logic              range_err
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY);

    fetch_state_e      state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [2:0]        lat_q, lat_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              clock_enable_q, clock_enable_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              align_fault_q, align_fault_d;
    logic              range_err_q, range_err_d;

    logic              misaligned;
    logic              out_of_range;
    logic              asm_clear;
    logic              asm_load;
    logic [31:0]       asm_word;
    logic              cache_hit;
    logic [31:0]       cache_word;

    assign misaligned   = (pc[1:0] != 2'b00);
    assign out_of_range = (pc[31:ADDR_W] != {(32-ADDR_W){1'b0}});

    byte_assembler #(
        .CLEAR_WORD (NOP_WORD)
    ) u_byte_assembler (
        .clk   (clk),
        .reset (reset),
        .clear (asm_clear),
        .load  (asm_load),
        .idx   (k_q),
        .din   (mem_rdata),
        .word  (asm_word)
    );

`ifdef FETCH_CACHE_EN
    logic        cache_valid_q, cache_valid_d;
    logic [31:0] cache_tag_q, cache_tag_d;
    logic [31:0] cache_word_q, cache_word_d;

    assign cache_hit  = cache_valid_q && (cache_tag_q == pc);
    assign cache_word = cache_word_q;

    // Only a completed memory fetch (WAIT -> DONE) fills the entry.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_word_d  = cache_word_q;
        if ((state_q == WAIT) && (state_d == DONE)) begin
            cache_valid_d = 1'b1;
            cache_tag_d   = pc;
            cache_word_d  = instr_d;
        end else begin
            cache_valid_d = cache_valid_q;
        end
    end

    // Cache entry registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= 32'h0000_0000;
            cache_word_q  <= NOP_WORD;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_word_q  <= cache_word_d;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_word = NOP_WORD;
`endif

    // Fetch sequencing; outputs are registered from the next state so they line up with it.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        lat_d         = lat_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        align_fault_d = align_fault_q;
        range_err_d   = 1'b0;
        asm_clear     = 1'b0;
        asm_load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    state_d       = HALT;
                    align_fault_d = 1'b1;
                    instr_d       = NOP_WORD;
                    instr_valid_d = 1'b0;
                end else if (out_of_range) begin
                    state_d       = DONE;
                    instr_d       = NOP_WORD;
                    instr_valid_d = 1'b1;
                    range_err_d   = 1'b1;
                end else if (cache_hit) begin
                    state_d       = DONE;
                    instr_d       = cache_word;
                    instr_valid_d = 1'b1;
                end else begin
                    state_d       = ISSUE;
                    k_d           = 2'd0;
                    instr_valid_d = 1'b0;
                    asm_clear     = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = 3'd1;
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    asm_load = 1'b1;
                    if (k_q == 2'd3) begin
                        // The last byte bypasses the assembler so instr is complete in DONE.
                        state_d       = DONE;
                        instr_d       = asm_word;
                        instr_d[byte_lane_lsb(k_q) +: BYTE_W] = mem_rdata;
                        instr_valid_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        k_d     = k_q + 2'd1;
                    end
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            HALT: begin
                state_d = HALT;
                instr_d = NOP_WORD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        clock_enable_d = (state_d == DONE);
        mem_en_d       = (state_d == ISSUE);
        mem_addr_d     = mem_en_d ? (pc[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, k_d}) : mem_addr_q;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            k_q            <= 2'd0;
            lat_q          <= 3'd0;
            instr_q        <= NOP_WORD;
            instr_valid_q  <= 1'b0;
            clock_enable_q <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_addr_q     <= {ADDR_W{1'b0}};
            align_fault_q  <= 1'b0;
            range_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            lat_q          <= lat_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            clock_enable_q <= clock_enable_d;
            mem_en_q       <= mem_en_d;
            mem_addr_q     <= mem_addr_d;
            align_fault_q  <= align_fault_d;
            range_err_q    <= range_err_d;
        end
    end

    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign clock_enable = clock_enable_q;
    assign mem_en       = mem_en_q;
    assign mem_addr     = mem_addr_q;
    assign align_fault  = align_fault_q;
    assign range_err    = range_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (ROM latency 1 and 3) driven from
// randomized fetch sequences and checked against a word/latency/cache model.
module tb_instr_fetch_unit;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
`ifdef FETCH_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk;
    logic        reset        [2];
    logic [31:0] pc           [2];
    logic [31:0] instr        [2];
    logic        instr_valid  [2];
    logic        clock_enable [2];
    logic        mem_en       [2];
    logic [9:0]  mem_addr     [2];
    logic [7:0]  mem_rdata    [2];
    logic        align_fault  [2];
    logic        range_err    [2];

    logic [7:0]  rom    [2][1024];
    logic [9:0]  pipe_a [2][4];
    logic        pipe_v [2][4];

    logic        cv   [2];
    logic [31:0] ctag [2];

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.ADDR_W(10), .MEM_LATENCY(LAT0)) dut0 (
        .clk(clk), .reset(reset[0]), .pc(pc[0]), .instr(instr[0]),
        .instr_valid(instr_valid[0]), .clock_enable(clock_enable[0]),
        .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
        .align_fault(align_fault[0]), .range_err(range_err[0])
    );

    instr_fetch_unit #(.ADDR_W(10), .MEM_LATENCY(LAT1)) dut1 (
        .clk(clk), .reset(reset[1]), .pc(pc[1]), .instr(instr[1]),
        .instr_valid(instr_valid[1]), .clock_enable(clock_enable[1]),
        .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
        .align_fault(align_fault[1]), .range_err(range_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models: data for a strobed address appears LAT cycles later.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pipe_a[d][0] <= mem_addr[d];
            pipe_v[d][0] <= mem_en[d];
            for (int s = 1; s < 4; s++) begin
                pipe_a[d][s] <= pipe_a[d][s-1];
                pipe_v[d][s] <= pipe_v[d][s-1];
            end
        end
    end

    assign mem_rdata[0] = (pipe_v[0][LAT0-1] === 1'b1) ? rom[0][pipe_a[0][LAT0-1]] : 8'hEE;
    assign mem_rdata[1] = (pipe_v[1][LAT1-1] === 1'b1) ? rom[1][pipe_a[1][LAT1-1]] : 8'hEE;

    // One fetch on instance d (the other is held in reset); called at a negedge with d idle.
    task automatic do_fetch(input int d, input logic [31:0] addr, input string name);
        int          lat, t0, tdone, n_en, exp_done, exp_en;
        bit          oor, hit, en_ok, drop_ok;
        logic [31:0] exp_word, got_word;
        logic        got_valid, got_rerr;
        lat       = (d == 0) ? LAT0 : LAT1;
        oor       = (addr >= 32'h0000_0400);
        hit       = CACHE_ON && (cv[d] === 1'b1) && (ctag[d] == addr) && !oor;
        exp_word  = oor ? 32'h0000_0000 :
                    {rom[d][addr[9:0]], rom[d][addr[9:0] + 10'd1],
                     rom[d][addr[9:0] + 10'd2], rom[d][addr[9:0] + 10'd3]};
        exp_done  = (oor || hit) ? 1 : 1 + 4 * (lat + 1);
        exp_en    = (oor || hit) ? 0 : 4;
        t0 = -1; tdone = -1; n_en = 0; en_ok = 1'b1; drop_ok = 1'b1;
        got_word = 32'hxxxx_xxxx; got_valid = 1'bx; got_rerr = 1'bx;

        reset[1-d] = 1'b1;
        cv[1-d]    = 1'b0;
        reset[d]   = 1'b0;
        pc[d]      = addr;
        for (int c = 1; c <= 64 && tdone < 0; c++) begin
            @(negedge clk);
            if (mem_en[d] === 1'b1) begin
                if (t0 < 0) begin
                    t0 = c;
                    drop_ok = (instr_valid[d] === 1'b0);
                end
                if ((c - t0) != n_en * (lat + 1) || mem_addr[d] !== 10'(addr[9:0] + 10'(n_en)))
                    en_ok = 1'b0;
                n_en++;
            end
            if (clock_enable[d] === 1'b1) begin
                tdone     = c;
                got_word  = instr[d];
                got_valid = instr_valid[d];
                got_rerr  = range_err[d];
            end
        end

        checks++;
        if (tdone !== exp_done) begin
            errors++;
            $display("FAIL %s latency: pc=%h got %0d expected %0d", name, addr, tdone, exp_done);
        end
        checks++;
        if (n_en !== exp_en || !en_ok) begin
            errors++;
            $display("FAIL %s mem_en: pc=%h strobes=%0d order_ok=%0d expected %0d strobes at pc+k every %0d cycles",
                     name, addr, n_en, en_ok, exp_en, lat + 1);
        end
        checks++;
        if (got_word !== exp_word) begin
            errors++;
            $display("FAIL %s instr: pc=%h got %h expected %h", name, addr, got_word, exp_word);
        end
        checks++;
        if (got_valid !== 1'b1 || got_rerr !== oor) begin
            errors++;
            $display("FAIL %s flags: pc=%h valid=%b range_err=%b expected valid=1 range_err=%b",
                     name, addr, got_valid, got_rerr, oor);
        end
        if (exp_en > 0) begin
            checks++;
            if (!drop_ok) begin
                errors++;
                $display("FAIL %s valid_drop: instr_valid not 0 on first ISSUE, expected 0", name);
            end
        end

        @(negedge clk);
        checks++;
        if (clock_enable[d] !== 1'b0 || range_err[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: ce=%b range_err=%b one cycle after DONE, expected 0 0",
                     name, clock_enable[d], range_err[d]);
        end
        if (!oor) begin
            cv[d]   = 1'b1;
            ctag[d] = addr;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1;
            pc[d]    = 32'h0;
            cv[d]    = 1'b0;
            ctag[d]  = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({instr[d], instr_valid[d], clock_enable[d], mem_en[d], mem_addr[d], align_fault[d], range_err[d]}
                !== {32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_values dut%0d: instr=%h v=%b ce=%b en=%b addr=%h af=%b re=%b expected all zero",
                         d, instr[d], instr_valid[d], clock_enable[d], mem_en[d], mem_addr[d],
                         align_fault[d], range_err[d]);
            end
        end
    endtask

    task automatic test_basic();
        do_fetch(0, 32'h0000_0000, "basic_pc0");
        checks++;
        if (instr[0] !== 32'h8C01_0004) begin
            errors++;
            $display("FAIL basic_word: got %h expected 8c010004", instr[0]);
        end
    endtask

    task automatic test_latency3();
        do_fetch(1, 32'h0000_0010, "lat3_pc10");
    endtask

    task automatic test_range();
        do_fetch(0, 32'h0000_0400, "range_400");
        do_fetch(0, 32'hFFFF_FFFC, "range_top");
    endtask

    task automatic test_cache_repeat();
        do_fetch(0, 32'h0000_0020, "repeat_first");
        do_fetch(0, 32'h0000_0020, "repeat_second");
        do_fetch(0, 32'h0000_0800, "repeat_range");
        do_fetch(0, 32'h0000_0020, "repeat_after_range");
    endtask

    task automatic test_reset_midfetch();
        bit ce_seen;
        do_fetch(0, 32'h0000_0040, "mid_pre");
        pc[0]   = 32'h0000_0080;
        ce_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (clock_enable[0] === 1'b1) ce_seen = 1'b1;
        end
        reset[0] = 1'b1;
        cv[0]    = 1'b0;
        @(negedge clk);
        if (clock_enable[0] === 1'b1) ce_seen = 1'b1;
        checks++;
        if ({instr[0], instr_valid[0], clock_enable[0], mem_en[0], mem_addr[0], align_fault[0], range_err[0]}
            !== {32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_values: instr=%h v=%b ce=%b en=%b addr=%h expected all zero",
                     instr[0], instr_valid[0], clock_enable[0], mem_en[0], mem_addr[0]);
        end
        checks++;
        if (ce_seen) begin
            errors++;
            $display("FAIL mid_reset_pulse: got clock_enable during abandoned fetch, expected none");
        end
        do_fetch(0, 32'h0000_0040, "mid_after_a");
        do_fetch(0, 32'h0000_0080, "mid_after_b");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] prev;
        int          r;
        prev = 32'h0000_0100;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      a = ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
            else if (r < 5) a = prev;
            else            a = {22'h0, 8'($urandom), 2'b00};
            do_fetch((i < 16) ? 0 : 1, a, "random");
            if (a < 32'h0000_0400) prev = a;
        end
    endtask

    task automatic test_misaligned();
        int          d, n_ce, n_en, n_re, span;
        logic [31:0] a;
        for (int t = 0; t < 2; t++) begin
            d    = (t == 0) ? 1 : 0;
            a    = (t == 0) ? 32'h0000_0006 : 32'h0000_0402;
            span = (t == 0) ? 100 : 20;
            do_fetch(d, 32'h0000_0024, "mis_pre");
            pc[d] = a;
            n_ce = 0; n_en = 0; n_re = 0;
            for (int c = 0; c < span; c++) begin
                @(negedge clk);
                if (clock_enable[d] === 1'b1) n_ce++;
                if (mem_en[d] === 1'b1)       n_en++;
                if (range_err[d] === 1'b1)    n_re++;
            end
            checks++;
            if (n_ce != 0 || n_en != 0 || n_re != 0) begin
                errors++;
                $display("FAIL halt_quiet pc=%h: ce=%0d mem_en=%0d range_err=%0d pulses, expected 0 0 0",
                         a, n_ce, n_en, n_re);
            end
            checks++;
            if (align_fault[d] !== 1'b1 || instr[d] !== 32'h0000_0000) begin
                errors++;
                $display("FAIL halt_state pc=%h: align_fault=%b instr=%h expected 1 00000000",
                         a, align_fault[d], instr[d]);
            end
            reset[d] = 1'b1;
            cv[d]    = 1'b0;
            @(negedge clk);
            checks++;
            if (align_fault[d] !== 1'b0) begin
                errors++;
                $display("FAIL halt_clear pc=%h: align_fault=%b after reset expected 0", a, align_fault[d]);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++)
                rom[d][i] = 8'($urandom);
        rom[0][0] = 8'h8C;
        rom[0][1] = 8'h01;
        rom[0][2] = 8'h00;
        rom[0][3] = 8'h04;

        test_reset();
        test_basic();
        test_latency3();
        test_range();
        test_cache_repeat();
        test_reset_midfetch();
        test_random();
        test_misaligned();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
